// File: rtl/main_run_ctrl_pkg.sv
// Shared types and constants for the run controller in front of the `main` accelerator.
package main_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_START  = 3'd3,
        ST_RUN    = 3'd4,
        ST_REPORT = 3'd5
    } run_state_t;

    // Result status codes carried in res_status.
    localparam logic [1:0] RES_DONE        = 2'd0;
    localparam logic [1:0] RES_RUN_TIMEOUT = 2'd1;
    localparam logic [1:0] RES_WR_TIMEOUT  = 2'd2;
    localparam logic [1:0] RES_BAD_LEN     = 2'd3;

    // Access size presented on S_data_ram_size for a byte write.
    localparam logic [7:0] RAM_SIZE_BYTE = 8'd8;

    // Zero-extend one image byte onto the 16-bit slave write bus.
    function automatic logic [15:0] byte_to_word(input logic [7:0] b);
        return {8'h00, b};
    endfunction

endpackage

// File: rtl/main_run_ctrl_cycle_counter.sv
// Saturating-at-limit cycle counter: clear, load-with-one, enable, and a
// flag that is high while the count equals LIMIT. Used both for the run
// measurement and for the per-write acknowledge watchdog.
module run_cycle_counter
    import main_run_ctrl_pkg::*;
#(
    parameter int             W     = 32,
    parameter logic [W-1:0]   LIMIT = W'(1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tmo
);

    logic [W-1:0] count_r;

    // Count register: clear has priority, then load-one, then increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= {{(W-1){1'b0}}, 1'b1};
        end else if (en) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tmo   = (count_r == LIMIT);

endmodule

// File: rtl/main_run_ctrl.sv
// Run controller for the `main` accelerator: loads an input byte image through
// the slave RAM port, pulses start_port, times the run until done_port and
// reports one (status, cycles) record.
module main_run_ctrl
    import main_run_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 16,
    parameter int CYC_W     = 32,
    parameter int MEM_BYTES = 32,
    parameter int TIMEOUT   = 200000000,
    parameter int WR_TMO    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [15:0]       cfg_len,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [7:0]        byte_data,
    output logic              start_port,
    input  logic              done_port,
    output logic [1:0]        S_oe_ram,
    output logic [1:0]        S_we_ram,
    output logic [ADDR_W-1:0] S_addr_ram,
    output logic [DATA_W-1:0] S_Wdata_ram,
    output logic [7:0]        S_data_ram_size,
    input  logic [1:0]        Sout_DataRdy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        res_status,
    output logic [CYC_W-1:0]  res_cycles,
    output logic              busy
);

    localparam int WD_W = $clog2(WR_TMO + 1);

    run_state_t        state_r;
    logic [ADDR_W-1:0] base_r;
    logic [15:0]       len_r;
    logic [15:0]       idx_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [7:0]        size_r;
    logic              we_r;
    logic              cfg_ready_r;
    logic              byte_ready_r;
    logic              start_r;
    logic              res_valid_r;
    logic [1:0]        status_r;
    logic [CYC_W-1:0]  cycles_r;
    logic              busy_r;

    logic [15:0]       idx_inc_s;
    logic              run_clr_s, run_load_s, run_en_s, run_tmo_s;
    logic [CYC_W-1:0]  run_cnt_s;
    logic              wd_clr_s, wd_load_s, wd_en_s, wd_tmo_s;
    logic [WD_W-1:0]   wd_cnt_unused_s;
    logic              rdy_unused_s;

    assign rdy_unused_s = Sout_DataRdy[1];

    // Counter controls: run counter starts at one on START, watchdog at one on byte accept.
    always_comb begin
        idx_inc_s  = idx_r + 16'd1;
        run_clr_s  = (state_r == ST_IDLE);
        run_load_s = (state_r == ST_START);
        run_en_s   = (state_r == ST_RUN) && !done_port && !run_tmo_s;
        wd_clr_s   = (state_r == ST_IDLE);
        wd_load_s  = (state_r == ST_FETCH) && byte_valid && byte_ready_r;
        wd_en_s    = (state_r == ST_WRITE) && !Sout_DataRdy[0] && !wd_tmo_s;
    end

    run_cycle_counter #(
        .W     (CYC_W),
        .LIMIT (CYC_W'(TIMEOUT))
    ) u_run_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (run_clr_s),
        .load  (run_load_s),
        .en    (run_en_s),
        .count (run_cnt_s),
        .tmo   (run_tmo_s)
    );

    run_cycle_counter #(
        .W     (WD_W),
        .LIMIT (WD_W'(WR_TMO))
    ) u_wr_wdog (
        .clock (clock),
        .reset (reset),
        .clr   (wd_clr_s),
        .load  (wd_load_s),
        .en    (wd_en_s),
        .count (wd_cnt_unused_s),
        .tmo   (wd_tmo_s)
    );

    // Control FSM; every output is a register updated together with the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            base_r       <= '0;
            len_r        <= 16'd0;
            idx_r        <= 16'd0;
            addr_r       <= '0;
            wdata_r      <= '0;
            size_r       <= 8'd0;
            we_r         <= 1'b0;
            cfg_ready_r  <= 1'b1;
            byte_ready_r <= 1'b0;
            start_r      <= 1'b0;
            res_valid_r  <= 1'b0;
            status_r     <= 2'd0;
            cycles_r     <= '0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_valid && cfg_ready_r) begin
                        base_r      <= cfg_base;
                        len_r       <= cfg_len;
                        idx_r       <= 16'd0;
                        cfg_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (cfg_len > 16'(MEM_BYTES)) begin
                            status_r    <= RES_BAD_LEN;
                            cycles_r    <= '0;
                            res_valid_r <= 1'b1;
                            state_r     <= ST_REPORT;
                        end else if (cfg_len == 16'd0) begin
                            start_r <= 1'b1;
                            state_r <= ST_START;
                        end else begin
                            byte_ready_r <= 1'b1;
                            state_r      <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (byte_valid) begin
                        byte_ready_r <= 1'b0;
                        addr_r       <= base_r + ADDR_W'(idx_r);
                        wdata_r      <= DATA_W'(byte_to_word(byte_data));
                        size_r       <= RAM_SIZE_BYTE;
                        we_r         <= 1'b1;
                        state_r      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (Sout_DataRdy[0]) begin
                        we_r    <= 1'b0;
                        size_r  <= 8'd0;
                        addr_r  <= '0;
                        wdata_r <= '0;
                        idx_r   <= idx_inc_s;
                        if (idx_inc_s == len_r) begin
                            start_r <= 1'b1;
                            state_r <= ST_START;
                        end else begin
                            byte_ready_r <= 1'b1;
                            state_r      <= ST_FETCH;
                        end
                    end else if (wd_tmo_s) begin
                        we_r        <= 1'b0;
                        size_r      <= 8'd0;
                        addr_r      <= '0;
                        wdata_r     <= '0;
                        status_r    <= RES_WR_TIMEOUT;
                        cycles_r    <= '0;
                        res_valid_r <= 1'b1;
                        state_r     <= ST_REPORT;
                    end
                end
                ST_START: begin
                    start_r <= 1'b0;
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (done_port) begin
                        status_r    <= RES_DONE;
                        cycles_r    <= run_cnt_s;
                        res_valid_r <= 1'b1;
                        state_r     <= ST_REPORT;
                    end else if (run_tmo_s) begin
                        status_r    <= RES_RUN_TIMEOUT;
                        cycles_r    <= CYC_W'(TIMEOUT);
                        res_valid_r <= 1'b1;
                        state_r     <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        cfg_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    we_r         <= 1'b0;
                    size_r       <= 8'd0;
                    byte_ready_r <= 1'b0;
                    start_r      <= 1'b0;
                    res_valid_r  <= 1'b0;
                    cfg_ready_r  <= 1'b1;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready       = cfg_ready_r;
    assign byte_ready      = byte_ready_r;
    assign start_port      = start_r;
    assign S_oe_ram        = 2'b00;
    assign S_we_ram        = {1'b0, we_r};
    assign S_addr_ram      = addr_r;
    assign S_Wdata_ram     = wdata_r;
    assign S_data_ram_size = size_r;
    assign res_valid       = res_valid_r;
    assign res_status      = status_r;
    assign res_cycles      = cycles_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_main_run_ctrl.sv
// Directed bench for main_run_ctrl with a transaction-level model: expected
// writes, start count, write-cycle count and result record are derived from
// the run description, and one compare process checks the DUT every cycle.
module tb_main_run_ctrl;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 16;
    localparam int CYC_W     = 32;
    localparam int MEM_BYTES = 32;
    localparam int TIMEOUT   = 50;
    localparam int WR_TMO    = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [15:0]       cfg_len = 16'd0;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic [7:0]        byte_data = 8'h00;
    logic              start_port;
    logic              done_port = 1'b0;
    logic [1:0]        S_oe_ram, S_we_ram;
    logic [ADDR_W-1:0] S_addr_ram;
    logic [DATA_W-1:0] S_Wdata_ram;
    logic [7:0]        S_data_ram_size;
    logic [1:0]        Sout_DataRdy = 2'b00;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [1:0]        res_status;
    logic [CYC_W-1:0]  res_cycles;
    logic              busy;

    always #5 clock = ~clock;

    main_run_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W),
        .MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT), .WR_TMO(WR_TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .start_port(start_port), .done_port(done_port),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_DataRdy(Sout_DataRdy),
        .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status),
        .res_cycles(res_cycles), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Environment controls and model state.
    logic [7:0]  byte_q[$];
    logic [29:0] exp_wr[$];       // {addr, data}
    bit          ack_en = 1'b0;
    int          done_delay = -1;
    int          done_cnt = 0;
    bit          model_busy = 1'b0;
    logic [1:0]  exp_status = 2'd0;
    logic [31:0] exp_cycles = 32'd0;
    int          start_cnt = 0;
    int          we_cycles = 0;
    int          res_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Environment: byte source, write acknowledger (one cycle after request), stub main.
    initial begin : env
        bit hs;
        bit rv;
        int wcyc;
        wcyc = 0;
        forever begin
            @(negedge clock);
            hs = byte_valid && byte_ready;
            rv = res_valid;
            if (start_port && done_delay > 0) done_cnt = done_delay;
            @(posedge clock);
            #1;
            if (hs && byte_q.size() > 0) void'(byte_q.pop_front());
            byte_valid = (byte_q.size() > 0);
            byte_data  = byte_valid ? byte_q[0] : 8'h00;
            if (S_we_ram[0]) wcyc++; else wcyc = 0;
            Sout_DataRdy = (ack_en && wcyc == 2) ? 2'b01 : 2'b00;
            if (rv) begin
                done_port = 1'b0;
                done_cnt  = 0;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) done_port = 1'b1;
            end
        end
    end

    // Compare process: per-cycle checks against the model on the falling edge.
    initial begin : cmp
        logic       prev_start, prev_valid, prev_ready;
        logic [1:0] prev_status;
        logic [31:0] prev_cycles;
        logic [29:0] w;
        prev_start = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
        prev_status = 2'd0; prev_cycles = 32'd0;
        forever begin
            @(negedge clock);
            if (reset) begin
                chk("oe_zero", S_oe_ram, 2'b00);
                chk("we1_zero", S_we_ram[1], 1'b0);
                chk("size", S_data_ram_size, S_we_ram[0] ? 8'd8 : 8'd0);
                chk("busy", busy, model_busy);
                chk("cfg_ready", cfg_ready, !model_busy);
                if (S_we_ram[0]) we_cycles++;
                if (S_we_ram[0] && Sout_DataRdy[0]) begin
                    if (exp_wr.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none pending", S_addr_ram, S_Wdata_ram);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", S_addr_ram, w[29:16]);
                        chk("wr_data", S_Wdata_ram, w[15:0]);
                    end
                end
                if (start_port) begin
                    start_cnt++;
                    chk("start_one_cycle", prev_start, 1'b0);
                end
                if (res_valid) begin
                    if (!prev_valid) begin
                        res_seen++;
                        chk("res_status", res_status, exp_status);
                        chk("res_cycles", res_cycles, exp_cycles);
                    end else if (!prev_ready) begin
                        chk("res_status_held", res_status, prev_status);
                        chk("res_cycles_held", res_cycles, prev_cycles);
                    end
                end
            end
            prev_start  = start_port;
            prev_valid  = res_valid;
            prev_ready  = res_ready;
            prev_status = res_status;
            prev_cycles = res_cycles;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cfg_ready"}, cfg_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_we"}, S_we_ram, 2'b00);
        chk({tag, "_size"}, S_data_ram_size, 8'd0);
        chk({tag, "_byte_ready"}, byte_ready, 1'b0);
        chk({tag, "_start"}, start_port, 1'b0);
        chk({tag, "_res_valid"}, res_valid, 1'b0);
        chk({tag, "_res_status"}, res_status, 2'd0);
        chk({tag, "_res_cycles"}, res_cycles, 32'd0);
    endtask

    // One complete run: model expectations derived from the run description,
    // status/cycles given as hand-computed literals.
    task automatic run_case(input string nm, input logic [13:0] base, input logic [15:0] len,
                            input logic [7:0] first_byte, input bit ack, input int ddelay,
                            input logic [1:0] est, input logic [31:0] ecyc,
                            input int hold_lo, input int elat);
        int  lat;
        int  exp_starts;
        int  exp_we;
        bit  ok;
        logic [13:0] a;
        logic [7:0]  b;
        exp_wr.delete();
        if (len <= 16'(MEM_BYTES)) begin
            for (int i = 0; i < int'(len); i++) begin
                a = base + 14'(i);
                b = first_byte + 8'(i);
                byte_q.push_back(b);
                if (ack) exp_wr.push_back({a, 8'h00, b});
            end
        end
        if (len > 16'(MEM_BYTES))       begin exp_starts = 0; exp_we = 0; end
        else if (len == 16'd0)          begin exp_starts = 1; exp_we = 0; end
        else if (!ack)                  begin exp_starts = 0; exp_we = WR_TMO; end
        else                            begin exp_starts = 1; exp_we = 2 * int'(len); end
        ack_en = ack; done_delay = ddelay;
        exp_status = est; exp_cycles = ecyc;
        start_cnt = 0; we_cycles = 0; res_seen = 0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clock); #1;
            ok = cfg_ready;
        end
        chk({nm, "_cfg_ready_wait"}, ok, 1'b1);
        cfg_base = base; cfg_len = len; cfg_valid = 1'b1;
        @(posedge clock); #1;
        cfg_valid = 1'b0; model_busy = 1'b1;
        lat = 0;
        while (!res_valid && lat < 400) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({nm, "_res_valid_seen"}, res_valid, 1'b1);
        if (elat >= 0) chk({nm, "_latency"}, lat, elat);
        repeat (hold_lo) @(posedge clock);
        #1;
        res_ready = 1'b1;
        @(posedge clock); #1;
        res_ready = 1'b0; model_busy = 1'b0;
        chk({nm, "_res_valid_clr"}, res_valid, 1'b0);
        chk({nm, "_records"}, res_seen, 1);
        chk({nm, "_starts"}, start_cnt, exp_starts);
        chk({nm, "_we_cycles"}, we_cycles, exp_we);
        chk({nm, "_writes_left"}, exp_wr.size(), 0);
        byte_q.delete();
        done_delay = -1;
        repeat (2) @(posedge clock);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin : main_seq
        bit seen;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b1;

        // 4 bytes at 0x10, ack one cycle later, done 7 cycles after start.
        run_case("load4", 14'h0010, 16'd4, 8'h01, 1'b1, 7, 2'd0, 32'd7, 0, -1);
        // Length one past the limit: reported on the next cycle, nothing written.
        run_case("badlen", 14'h0000, 16'd33, 8'h00, 1'b1, 7, 2'd3, 32'd0, 0, 0);
        // No acknowledge: 1 fetch cycle + 16 write cycles, then WR_TIMEOUT.
        run_case("wrtmo", 14'h0005, 16'd3, 8'h40, 1'b0, 7, 2'd2, 32'd0, 0, 17);
        // Address wrap at the top of the slave space, done never: run timeout, record held.
        run_case("runtmo", 14'h3FFF, 16'd2, 8'hAA, 1'b1, -1, 2'd1, 32'd50, 5, -1);
        // Maximum length, done in the first run cycle.
        run_case("max32", 14'h0100, 16'd32, 8'hC0, 1'b1, 1, 2'd0, 32'd1, 0, -1);

        // Reset in the middle of a write.
        byte_q.push_back(8'h11);
        byte_q.push_back(8'h22);
        ack_en = 1'b0;
        @(posedge clock); #1;
        cfg_base = 14'h0020; cfg_len = 16'd2; cfg_valid = 1'b1;
        @(posedge clock); #1;
        cfg_valid = 1'b0; model_busy = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clock); #1;
            seen = S_we_ram[0];
        end
        chk("midwr_we_seen", seen, 1'b1);
        @(negedge clock); #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midwr");
        model_busy = 1'b0;
        exp_wr.delete();
        byte_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        // Fresh zero-length run after the reset.
        run_case("len0", 14'h0000, 16'd0, 8'h00, 1'b1, 3, 2'd0, 32'd3, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
